// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with ack-timeout fault detection and a saturating cycle counter.
`default_nettype none

module riscv_mc_controller #(
  parameter int CNT_W       = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] clock_count
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(ACK_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_reg_we, w_pc_we;
  logic [1:0] w_pc_sel, w_wb_sel;
  logic       w_alu_src_imm;

  logic w_is_load, w_is_store, w_is_legal;
  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);
  assign w_is_legal = (opcode == OP_R) || (opcode == OP_I) || w_is_load || w_is_store ||
                      (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_LUI);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    done_d        = done_q;
    fault_d       = fault_q;
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_ir_we       = 1'b0;
    w_reg_we      = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_sel      = 2'd2;
    w_wb_sel      = 2'd0;
    w_alu_src_imm = 1'b0;

    case (state_q)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_we = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT_VAL) begin
          // The wait already spans ACK_TIMEOUT cycles; an ack in this cycle
          // would still have been taken above.
          state_d = S_HALT;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (w_is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end
      end
      S_EXEC: begin
        w_alu_src_imm = (opcode == OP_I) || w_is_load || w_is_store || (opcode == OP_LUI);
        if (opcode == OP_BRANCH) begin
          w_pc_we  = 1'b1;
          w_pc_sel = branch_taken ? 2'd1 : 2'd0;
          state_d  = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_store;
        if (dmem_ack) begin
          if (w_is_store) begin
            w_pc_we  = 1'b1;
            w_pc_sel = 2'd0;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TIMEOUT_VAL) begin
          state_d = S_HALT;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        w_wb_sel = w_is_load ? 2'd1 : ((opcode == OP_JAL) ? 2'd2 : 2'd0);
        w_pc_sel = (opcode == OP_JAL) ? 2'd1 : 2'd0;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if ((state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q)) begin
      wait_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_HALT && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Gating with rst_n forces requests/strobes low the instant reset asserts.
  assign imem_req    = w_imem_req & rst_n;
  assign dmem_req    = w_dmem_req & rst_n;
  assign dmem_we     = w_dmem_we & rst_n;
  assign ir_we       = w_ir_we & rst_n;
  assign reg_we      = w_reg_we & rst_n;
  assign pc_we       = w_pc_we & rst_n;
  assign pc_sel      = w_pc_sel;
  assign wb_sel      = w_wb_sel;
  assign alu_src_imm = w_alu_src_imm & rst_n;
  assign done        = done_q;
  assign fault       = fault_q;
  assign clock_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mc_controller.sv
// Directed self-checking bench for riscv_mc_controller.
`default_nettype none

module tb_riscv_mc_controller;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, alu_src_imm, done, fault;
  logic [1:0]  pc_sel, wb_sel;
  logic [15:0] clock_count;

  // Second, narrow-counter instance running an endless ADDI loop.
  logic        s_rst_n;
  logic [6:0]  s_opcode;
  logic        s_imem_ack, s_dmem_ack, s_bt;
  logic        s_imem_req, s_dmem_req, s_dmem_we, s_ir_we, s_reg_we, s_pc_we, s_alu, s_done, s_fault;
  logic [1:0]  s_pc_sel, s_wb_sel;
  logic [7:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_mc_controller #(.CNT_W(16), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .done(done), .fault(fault),
    .clock_count(clock_count)
  );

  riscv_mc_controller #(.CNT_W(8), .ACK_TIMEOUT(64)) dut_sat (
    .clk(clk), .rst_n(s_rst_n), .opcode(s_opcode), .branch_taken(s_bt),
    .imem_ack(s_imem_ack), .dmem_ack(s_dmem_ack), .imem_req(s_imem_req), .dmem_req(s_dmem_req),
    .dmem_we(s_dmem_we), .ir_we(s_ir_we), .reg_we(s_reg_we), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
    .wb_sel(s_wb_sel), .alu_src_imm(s_alu), .done(s_done), .fault(s_fault),
    .clock_count(s_count)
  );

  // {imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_sel, wb_sel, alu_src_imm}
  function automatic logic [10:0] ov(input logic ireq, input logic dreq, input logic dwe,
                                     input logic irwe, input logic rwe, input logic pwe,
                                     input logic [1:0] psel, input logic [1:0] wsel,
                                     input logic alu);
    return {ireq, dreq, dwe, irwe, rwe, pwe, psel, wsel, alu};
  endfunction

  logic [10:0] outs;
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_sel, wb_sel, alu_src_imm};

  localparam logic [10:0] O_FETCH_ACK  = 11'b1_0_0_1_0_0_10_00_0;
  localparam logic [10:0] O_FETCH_WAIT = 11'b1_0_0_0_0_0_10_00_0;
  localparam logic [10:0] O_IDLE       = 11'b0_0_0_0_0_0_10_00_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check(input string tag, input logic [10:0] exp);
    #2;
    check(tag, {21'd0, outs}, {21'd0, exp});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    branch_taken = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Fetch with immediate ack, then decode.
  task automatic fetch_decode(input string tag, input logic [6:0] op);
    opcode   = op;
    imem_ack = 1'b1;
    settle_check({tag, "_fetch"}, O_FETCH_ACK);
    tick();
    imem_ack = 1'b0;
    settle_check({tag, "_decode"}, O_IDLE);
    tick();
  endtask

  initial begin
    s_rst_n = 1'b0; s_opcode = OP_I; s_imem_ack = 1'b1; s_dmem_ack = 1'b0; s_bt = 1'b0;
    opcode = OP_I; rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b0;
    #3;
    check("reset_outs", {21'd0, outs}, {21'd0, O_IDLE & 11'b0_0_0_0_0_0_11_11_0});
    check("reset_count", {16'd0, clock_count}, 32'd0);
    check("reset_done_fault", {30'd0, done, fault}, 32'd0);
    tick();
    s_rst_n = 1'b1;
    do_reset();

    // ADDI: 4 cycles
    fetch_decode("addi", OP_I);
    settle_check("addi_exec", ov(0,0,0,0,0,0,2'd2,2'd0,1));
    tick();
    settle_check("addi_wb", ov(0,0,0,0,1,1,2'd0,2'd0,0));
    tick();
    check("addi_latency_count", {16'd0, clock_count}, 32'd4);

    // LW with dmem_ack delayed 3 cycles
    fetch_decode("lw", OP_LOAD);
    settle_check("lw_exec", ov(0,0,0,0,0,0,2'd2,2'd0,1));
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      settle_check("lw_mem", ov(0,1,0,0,0,0,2'd2,2'd0,0));
      tick();
    end
    dmem_ack = 1'b0;
    settle_check("lw_wb", ov(0,0,0,0,1,1,2'd0,2'd1,0));
    tick();

    // SW with immediate ack
    fetch_decode("sw", OP_STORE);
    settle_check("sw_exec", ov(0,0,0,0,0,0,2'd2,2'd0,1));
    tick();
    dmem_ack = 1'b1;
    settle_check("sw_mem", ov(0,1,1,0,0,1,2'd0,2'd0,0));
    tick();
    dmem_ack = 1'b0;
    settle_check("sw_back_fetch", O_FETCH_WAIT);

    // BEQ taken / not taken
    fetch_decode("beq_t", OP_BRANCH);
    branch_taken = 1'b1;
    settle_check("beq_taken_exec", ov(0,0,0,0,0,1,2'd1,2'd0,0));
    tick();
    fetch_decode("beq_n", OP_BRANCH);
    branch_taken = 1'b0;
    settle_check("beq_nt_exec", ov(0,0,0,0,0,1,2'd0,2'd0,0));
    tick();

    // JAL and R-type
    fetch_decode("jal", OP_JAL);
    settle_check("jal_exec", ov(0,0,0,0,0,0,2'd2,2'd0,0));
    tick();
    settle_check("jal_wb", ov(0,0,0,0,1,1,2'd1,2'd2,0));
    tick();
    fetch_decode("r", OP_R);
    settle_check("r_exec", ov(0,0,0,0,0,0,2'd2,2'd0,0));
    tick();
    tick();

    // Reset pulsed during MEM; a late dmem_ack must be ignored
    fetch_decode("rst_lw", OP_LOAD);
    tick();
    settle_check("rst_pre_mem", ov(0,1,0,0,0,0,2'd2,2'd0,0));
    rst_n = 1'b0;
    dmem_ack = 1'b1;
    #1;
    check("rst_mid_outs", {21'd0, outs}, {21'd0, O_IDLE});
    check("rst_mid_count", {16'd0, clock_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle_check("rst_restart_fetch", O_FETCH_WAIT);
    tick();
    settle_check("rst_late_ack_ignored", O_FETCH_WAIT);
    check("rst_count_after", {16'd0, clock_count}, 32'd1);
    dmem_ack = 1'b0;

    // 3 x ADDI then ECALL: halt after 14 cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch_decode("prog_addi", OP_I);
      tick();
      tick();
    end
    fetch_decode("prog_ecall", OP_SYSTEM);
    check("ecall_done_fault", {30'd0, done, fault}, 32'b10);
    check("ecall_count", {16'd0, clock_count}, 32'd14);
    settle_check("halt_outs", O_IDLE);
    imem_ack = 1'b1;
    repeat (5) tick();
    imem_ack = 1'b0;
    check("halt_count_frozen", {16'd0, clock_count}, 32'd14);
    check("halt_absorbing", {30'd0, done, fault}, 32'b10);

    // Illegal opcode 0x7F
    do_reset();
    fetch_decode("illegal", 7'h7F);
    check("illegal_done_fault", {30'd0, done, fault}, 32'b11);

    // imem_ack withheld: fault after the wait window
    begin
      int n_req;
      n_req = 0;
      do_reset();
      opcode = OP_I;
      for (int i = 0; i < 100 && !done; i++) begin
        #2;
        if (imem_req) n_req++;
        tick();
      end
      check("timeout_req_cycles", n_req, 32'd65);
      check("timeout_done_fault", {30'd0, done, fault}, 32'b11);
    end

    // Ack exactly at the timeout cycle is honoured
    do_reset();
    opcode = OP_I;
    repeat (64) tick();
    imem_ack = 1'b1;
    settle_check("tmo_edge_ack", O_FETCH_ACK);
    tick();
    imem_ack = 1'b0;
    check("tmo_edge_no_fault", {30'd0, done, fault}, 32'b00);
    settle_check("tmo_edge_decode", O_IDLE);
    tick();
    settle_check("tmo_edge_exec", ov(0,0,0,0,0,0,2'd2,2'd0,1));

    // Narrow counter saturation
    repeat (300) tick();
    check("sat_count", {24'd0, s_count}, 32'hFF);
    check("sat_not_done", {31'd0, s_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
